// File: rtl/schmidl_cox_rx_if.sv
// Sample-in / status-out bundle for the Schmidl-Cox preamble detector.
// Handshake: a sample transfers on every rising clk edge where i_valid is high.
// There is no ready; the detector accepts every sample. All outputs are registered
// state of the detector and change only on clk edges.
interface schmidl_cox_rx_if #(
    parameter int WIDTH = 10,
    parameter int ACC_W = 27
);
    logic                    i_valid;
    logic signed [WIDTH-1:0] i_data;
    logic                    o_detect;
    logic [7:0]              o_peak_offset;
    logic signed [ACC_W-1:0] o_metric_p;
    logic                    o_busy;
    logic [1:0]              o_dbg_state;   // 0 FILL, 1 SEARCH, 2 PLATEAU, 3 HOLDOFF

    modport master (
        output i_valid, i_data,
        input  o_detect, o_peak_offset, o_metric_p, o_busy, o_dbg_state
    );
    modport slave (
        input  i_valid, i_data,
        output o_detect, o_peak_offset, o_metric_p, o_busy, o_dbg_state
    );
endinterface

// File: rtl/schmidl_cox_rx.sv
// Streaming Schmidl-Cox preamble detector.
// Stage 1: delay line shift + tap products, stage 2: sliding P/R accumulators,
// stage 3: threshold compare and plateau-tracking FSM. Detect rises 3 clk after
// the i_valid cycle of the sample that ends the plateau.
module schmidl_cox_rx #(
    parameter int WIDTH             = 10,
    parameter int PREAMBLE_HALF_LEN = 64,
    parameter int LOG2_L            = 6,
    parameter int THRESH_NUM        = 7,
    parameter int MIN_ENERGY        = 1024
) (
    input  logic            clk,
    input  logic            reset,
    schmidl_cox_rx_if.slave sc_if
);
    localparam int L      = PREAMBLE_HALF_LEN;
    localparam int DL_LEN = 2 * L;
    localparam int PW     = 2 * WIDTH;
    localparam int ACC_W  = 2 * WIDTH + LOG2_L + 1;
    localparam int CMP_W  = ACC_W + 4;
    localparam int CW     = LOG2_L + 1;

    localparam logic [1:0] S_FILL    = 2'd0;
    localparam logic [1:0] S_SEARCH  = 2'd1;
    localparam logic [1:0] S_PLATEAU = 2'd2;
    localparam logic [1:0] S_HOLDOFF = 2'd3;

    // FILL, PLATEAU and HOLDOFF all last at most 2L updates, so one counter serves all.
    localparam logic [CW-1:0]          CNT_LAST = CW'(DL_LEN - 1);
    localparam logic [CW-1:0]          CNT_ONE  = CW'(1);
    localparam logic [ACC_W-1:0]       MIN_E    = ACC_W'(MIN_ENERGY);
    localparam logic signed [CMP_W-1:0] THR     = CMP_W'(THRESH_NUM);

    function automatic logic signed [PW-1:0] sx(input logic signed [WIDTH-1:0] v);
        return {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [ACC_W-1:0] acc_s(input logic signed [PW-1:0] v);
        return {{(ACC_W-PW){v[PW-1]}}, v};
    endfunction

    function automatic logic [ACC_W-1:0] acc_u(input logic [PW-1:0] v);
        return {{(ACC_W-PW){1'b0}}, v};
    endfunction

    // ---------------- stage 1: delay line and products ----------------
    logic signed [WIDTH-1:0] dl_q [DL_LEN];
    logic signed [WIDTH-1:0] tap_l, tap_2l;
    logic signed [PW-1:0]    p_new_d, p_old_d, p_new_q, p_old_q;
    logic [PW-1:0]           e_new_d, e_old_d, e_new_q, e_old_q;
    logic                    v1_q;

    // dl_q[k] holds x[n-1-k] while x[n] is on the input, so these are x[n-L] and x[n-2L].
    assign tap_l   = dl_q[L-1];
    assign tap_2l  = dl_q[DL_LEN-1];
    // The sample leaving the P window is rebuilt from the taps; no product history is kept.
    assign p_new_d = sx(sc_if.i_data) * sx(tap_l);
    assign p_old_d = sx(tap_l) * sx(tap_2l);
    assign e_new_d = $unsigned(sx(tap_l) * sx(tap_l));
    assign e_old_d = $unsigned(sx(tap_2l) * sx(tap_2l));

    // Shift the 2L-sample delay line on every valid sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DL_LEN; i++) dl_q[i] <= '0;
        end else if (sc_if.i_valid) begin
            dl_q[0] <= sc_if.i_data;
            for (int i = 1; i < DL_LEN; i++) dl_q[i] <= dl_q[i-1];
        end
    end

    // Register products and squares of the taps; v1_q marks a fresh set.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_new_q <= '0;
            p_old_q <= '0;
            e_new_q <= '0;
            e_old_q <= '0;
            v1_q    <= 1'b0;
        end else begin
            v1_q <= sc_if.i_valid;
            if (sc_if.i_valid) begin
                p_new_q <= p_new_d;
                p_old_q <= p_old_d;
                e_new_q <= e_new_d;
                e_old_q <= e_old_d;
            end
        end
    end

    // ---------------- stage 2: sliding accumulators ----------------
    logic signed [ACC_W-1:0] p_q, p_d;
    logic [ACC_W-1:0]        r_q, r_d;
    logic                    v2_q;

    assign p_d = p_q + acc_s(p_new_q) - acc_s(p_old_q);
    assign r_d = r_q + acc_u(e_new_q) - acc_u(e_old_q);

    // Update P and R once per registered product set; v2_q tells stage 3 they moved.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_q  <= '0;
            r_q  <= '0;
            v2_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                p_q <= p_d;
                r_q <= r_d;
            end
        end
    end

    // ---------------- stage 3: compare and FSM ----------------
    logic signed [CMP_W-1:0] p_cmp, r_cmp;
    logic                    p_pos, r_gate, ratio_ok, hit;

    assign p_cmp    = {{(CMP_W-ACC_W){p_q[ACC_W-1]}}, p_q};
    assign r_cmp    = {{(CMP_W-ACC_W){1'b0}}, r_q};
    assign p_pos    = !p_q[ACC_W-1] && (p_q != '0);
    assign r_gate   = r_q > MIN_E;
    assign ratio_ok = (p_cmp <<< 3) >= (r_cmp * THR);
    assign hit      = p_pos && r_gate && ratio_ok;

    logic [1:0]              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [ACC_W-1:0] pk_val_q, pk_val_d;
    logic [7:0]              pk_cnt_q, pk_cnt_d, pk_cnt_inc;
    logic                    det_q, det_d;
    logic [7:0]              off_q, off_d;

    assign pk_cnt_inc = (pk_cnt_q == 8'hFF) ? 8'hFF : pk_cnt_q + 8'd1;

    // Next-state logic; everything holds unless stage 2 just produced a new P/R.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pk_val_d = pk_val_q;
        pk_cnt_d = pk_cnt_q;
        det_d    = 1'b0;
        off_d    = off_q;
        if (v2_q) begin
            case (state_q)
                S_FILL: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_SEARCH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_SEARCH: begin
                    if (hit) begin
                        state_d  = S_PLATEAU;
                        pk_val_d = p_q;
                        pk_cnt_d = '0;
                        cnt_d    = '0;
                    end
                end
                S_PLATEAU: begin
                    pk_cnt_d = pk_cnt_inc;
                    // Strictly greater: on a tie the earlier peak wins.
                    if (p_q > pk_val_q) begin
                        pk_val_d = p_q;
                        pk_cnt_d = '0;
                    end
                    if (!hit || cnt_q == CNT_LAST) begin
                        det_d   = 1'b1;
                        off_d   = pk_cnt_d;
                        state_d = S_HOLDOFF;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_SEARCH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // FSM and output registers; reset drops any detect still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FILL;
            cnt_q    <= '0;
            pk_val_q <= '0;
            pk_cnt_q <= '0;
            det_q    <= 1'b0;
            off_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pk_val_q <= pk_val_d;
            pk_cnt_q <= pk_cnt_d;
            det_q    <= det_d;
            off_q    <= off_d;
        end
    end

    assign sc_if.o_detect      = det_q;
    assign sc_if.o_peak_offset = off_q;
    assign sc_if.o_metric_p    = p_q;
    assign sc_if.o_busy        = (state_q == S_PLATEAU) || (state_q == S_HOLDOFF);
    assign sc_if.o_dbg_state   = state_q;

endmodule

// File: doc/schmidl_cox_rx.md
Name: schmidl_cox_rx

Overview:
- Streaming Schmidl-Cox preamble detector for the receive path.
- Consumes real-valued baseband samples from the ADC front end and computes the sliding half-preamble autocorrelation P and energy R.
- Detects the plateau produced by the two identical preamble halves that the transmit-side preamble generator emits.
- Pulses a detect strobe with the sample offset of the correlation peak, so downstream symbol timing can align to the preamble end.

Parameters:
WIDTH, 10, input sample width, signed two's complement
PREAMBLE_HALF_LEN, 64, L: half-preamble length in samples; power of two, 8..128
LOG2_L, 6, log2(PREAMBLE_HALF_LEN)
THRESH_NUM, 7, detect when 8*P >= THRESH_NUM*R (ratio THRESH_NUM/8)
MIN_ENERGY, 1024, R must exceed this value for detection (noise gate)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
i_valid  in  1  i_data carries a new sample this cycle
i_data  in  WIDTH  signed sample
o_detect  out  1  one-cycle pulse: preamble detected
o_peak_offset  out  8  samples elapsed from the peak-P sample to the detect sample; held until next detect
o_metric_p  out  ACC_W  current P (signed); ACC_W = 2*WIDTH+LOG2_L+1
o_busy  out  1  high in PLATEAU or HOLDOFF

Behaviour:
- Reset: o_detect=0, o_peak_offset=0, o_metric_p=0, o_busy=0, P=R=0, delay line cleared, state=FILL, all counters 0.
- Delay line: 2L samples, shifts only on i_valid. x[n-L] and x[n-2L] are taps; cleared entries read as 0.
- Per valid sample n, compute all of the following:
  - p_n = x[n]*x[n-L], signed 2*WIDTH bits.
  - p_{n-L} is x[n-L]*x[n-2L], recomputed from taps with no product delay line.
  - P <= P + p_n - p_{n-L}, signed ACC_W.
  - R <= R + x[n-L]^2 - x[n-2L]^2, unsigned ACC_W.
  - No saturation needed; ACC_W covers the worst case.
- Pipeline: stage 1 registers products on i_valid; stage 2 updates P/R; stage 3 compares and runs the FSM.
  - The FSM advances only on the cycle after a P/R update (registered valid chain).
  - o_detect therefore rises exactly 3 clk after the i_valid cycle of the triggering sample. Bubbles in i_valid are preserved.
- Comparison: hit = (P > 0) && (R > MIN_ENERGY) && (8*P >= THRESH_NUM*R). Computed at ACC_W+4 bits, so there is no overflow.
- FSM states:
  - FILL: count 2L valid samples, then go to SEARCH. No detection in FILL.
  - SEARCH: on hit, go to PLATEAU; pk_val=P, pk_cnt=0.
  - PLATEAU: on each update, increment pk_cnt (saturating at 255).
    - If P > pk_val: pk_val=P, pk_cnt=0. Ties keep the earlier peak.
    - On !hit: o_detect=1 for one cycle, o_peak_offset=pk_cnt, go to HOLDOFF, hold_cnt=0.
    - If the plateau lasts 2L updates without a drop, force detect the same way.
  - HOLDOFF: ignore hits for 2L updates, then return to SEARCH.
- o_metric_p tracks P every cycle. o_busy = (state==PLATEAU || state==HOLDOFF).
- Reset mid-operation: all state returns to the reset values on the next edge. A pending detect is discarded and never pulses. FILL restarts.
- i_valid low: nothing shifts, accumulators hold, FSM holds, o_detect stays 0.

Test Plan:
1. Reset then 300 zero samples -> o_detect never asserts; P=R=0; FILL ends after sample 128.
2. 200 zero samples, then 64 samples of pattern A (±256 pseudo-random) repeated twice, then zeros:
   - At the end of the second half, P=R=64*65536.
   - o_detect pulses once, 3 clk after the first post-preamble sample that drops the metric below threshold.
   - o_peak_offset equals the samples from the peak to that sample.
3. Same as 2 but second half is independent random ±256 -> no detect (ratio well below 7/8).
4. Low-amplitude repeated preamble ±2 (R=256 < MIN_ENERGY) -> no detect.
5. Scenario 2 with i_valid toggling 1-0-1-0 -> identical P sequence and o_peak_offset; the detect cycle shifts only by the bubbles.
6. Scenario 2 with reset asserted during PLATEAU -> no o_detect pulse. A second preamble sent after 128 new fill samples is detected normally.
